mul_gen: RTL and testbench

MUL_GEN -- requirements
Module: mul_gen

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_gen.sv | 111 +++++++++++
 tb/tb_mul_gen.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg -- shared definitions for the mul_gen sequential multiplier.
//   state_t        : controller states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH  : default operand width used by mul_gen
package mul_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_gen.sv
// mul_gen -- radix-2 shift-add multiplier, signed or unsigned, one
// multiplier bit per clock, LSB first. Operands are converted to
// magnitudes on accept and the product sign is reapplied at the end.
//
// Ports:
//   clk_i     in   1        clock, all state changes on the rising edge
//   rst_i     in   1        synchronous active-low reset
//   a_bi      in   WIDTH    multiplicand, sampled on an accepted start
//   b_bi      in   WIDTH    multiplier, sampled on an accepted start
//   signed_i  in   1        1 = two's-complement operands, 0 = unsigned
//   start_i   in   1        start request, accepted only in IDLE
//   busy_o    out  1        high while an operation is in progress
//   valid_o   out  1        one-cycle pulse when y_bo is updated
//   y_bo      out  2*WIDTH  registered product, held until next result
module mul_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    input  logic                 signed_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   y_bo
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t                r_state;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic                  r_neg;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH-1:0]    r_y;
    logic                  r_valid;

    logic [WIDTH-1:0]      w_a_mag;
    logic [WIDTH-1:0]      w_b_mag;
    logic [2*WIDTH-1:0]    w_sum;
    logic [2*WIDTH-1:0]    w_result;
    logic                  w_last;

    // Negating the most negative value wraps back to itself, which read
    // as unsigned is exactly 2^(WIDTH-1): the correct magnitude.
    assign w_a_mag  = (signed_i && a_bi[WIDTH-1]) ? -a_bi : a_bi;
    assign w_b_mag  = (signed_i && b_bi[WIDTH-1]) ? -b_bi : b_bi;

    assign w_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_result = r_neg ? -r_acc : r_acc;
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // WIDTH shift-add steps, then one step that applies the
                    // sign and publishes the result on entry to DONE, so
                    // y_bo/valid_o are visible during DONE itself.
                    if (w_last) begin
                        r_y     <= w_result;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_acc    <= w_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (r_state != ST_IDLE);
    assign valid_o = r_valid;
    assign y_bo    = r_y;

endmodule

// File: tb/tb_mul_gen.sv
// tb_mul_gen -- self-checking bench for mul_gen. Three instances
// (WIDTH 8, 13, 16) share clock and reset; each scenario task drives one
// instance and checks against an integer-arithmetic reference product.
module tb_mul_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        st8, sg8, bz8, vl8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;

    logic        st13, sg13, bz13, vl13;
    logic [12:0] a13, b13;
    logic [25:0] y13;

    logic        st16, sg16, bz16, vl16;
    logic [15:0] a16, b16;
    logic [31:0] y16;

    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] last_y [3];

    mul_gen #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a8), .b_bi(b8), .signed_i(sg8),
        .start_i(st8), .busy_o(bz8), .valid_o(vl8), .y_bo(y8)
    );
    mul_gen #(.WIDTH(13)) u13 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a13), .b_bi(b13), .signed_i(sg13),
        .start_i(st13), .busy_o(bz13), .valid_o(vl13), .y_bo(y13)
    );
    mul_gen #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a16), .b_bi(b16), .signed_i(sg16),
        .start_i(st16), .busy_o(bz16), .valid_o(vl16), .y_bo(y16)
    );

    function automatic int wid(input int idx);
        return (idx == 0) ? 8 : (idx == 1) ? 13 : 16;
    endfunction

    // Reference: interpret operands as integers and multiply, then keep the
    // low 2*w bits (two's-complement view of the exact product).
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic s);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] rnd(input int w);
        return $urandom & ((32'd1 << w) - 32'd1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic st);
        case (idx)
            0: begin a8  = a[7:0];  b8  = b[7:0];  sg8  = s; st8  = st; end
            1: begin a13 = a[12:0]; b13 = b[12:0]; sg13 = s; st13 = st; end
            default: begin a16 = a[15:0]; b16 = b[15:0]; sg16 = s; st16 = st; end
        endcase
    endtask

    task automatic sample(input int idx, output logic bz, output logic vl,
                          output logic [63:0] y);
        case (idx)
            0: begin bz = bz8;  vl = vl8;  y = 64'(y8);  end
            1: begin bz = bz13; vl = vl13; y = 64'(y13); end
            default: begin bz = bz16; vl = vl16; y = 64'(y16); end
        endcase
    endtask

    // One full operation: accept on the next edge, then follow it until busy
    // drops, checking result, valid position/count and busy duration.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic scramble);
        int w, nv, vpos, nb;
        logic bz, vl, done;
        logic [63:0] y, got, exp;
        w    = wid(idx);
        exp  = ref_prod(w, a, b, s);
        drive(idx, a, b, s, 1'b1);
        tick();
        drive(idx, a, b, s, 1'b0);
        sample(idx, bz, vl, y);
        n_vec++;
        if (bz !== 1'b1) begin
            n_miss++;
            $display("FAIL accept_busy w=%0d: got %b expected 1", w, bz);
        end
        n_vec++;
        if (y !== last_y[idx]) begin
            n_miss++;
            $display("FAIL hold w=%0d: got %h expected %h", w, y, last_y[idx]);
        end
        nv = 0; vpos = -1; nb = 1; done = 1'b0; got = '0;
        for (int n = 1; n <= 100 && !done; n++) begin
            if (scramble) drive(idx, rnd(w), rnd(w), 1'($urandom & 1), 1'b0);
            tick();
            sample(idx, bz, vl, y);
            if (vl === 1'b1) begin
                nv++;
                if (vpos < 0) begin vpos = n; got = y; end
            end
            if (bz === 1'b1) nb++;
            else done = 1'b1;
        end
        $display("op w=%0d s=%0d a=%h b=%h y=%h exp=%h busy=%0d", w, s, a, b, got, exp, nb);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL product w=%0d a=%h b=%h s=%0d: got %h expected %h", w, a, b, s, got, exp);
        end
        n_vec++;
        if (vpos != w + 1) begin
            n_miss++;
            $display("FAIL valid_pos w=%0d: got %0d expected %0d", w, vpos, w + 1);
        end
        n_vec++;
        if (nv != 1) begin
            n_miss++;
            $display("FAIL valid_count w=%0d: got %0d expected 1", w, nv);
        end
        n_vec++;
        if (nb != w + 2) begin
            n_miss++;
            $display("FAIL busy_cycles w=%0d: got %0d expected %0d", w, nb, w + 2);
        end
        last_y[idx] = exp;
    endtask

    task automatic test_reset;
        logic bz, vl;
        logic [63:0] y;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 32'h5, 32'h7, 1'b0, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            sample(i, bz, vl, y);
            n_vec++;
            if (bz !== 1'b0 || vl !== 1'b0 || y !== 64'd0) begin
                n_miss++;
                $display("FAIL reset_state idx=%0d: got busy=%b valid=%b y=%h expected 0/0/0",
                         i, bz, vl, y);
            end
            last_y[i] = '0;
        end
        drive(1, 0, 0, 1'b0, 1'b0);
        drive(2, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_op(0, 32'h5, 32'h7, 1'b0, 1'b0);
    endtask

    task automatic test_directed;
        run_op(0, 32'hFF, 32'h06, 1'b0, 1'b0);
        run_op(0, 32'hFF, 32'h06, 1'b1, 1'b0);
        run_op(0, 32'h80, 32'h80, 1'b1, 1'b0);
        run_op(0, 32'h80, 32'h7F, 1'b1, 1'b0);
        run_op(0, 32'h00, 32'hA5, 1'b0, 1'b0);
        run_op(0, 32'h7F, 32'h00, 1'b1, 1'b0);
        run_op(2, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0);
        run_op(2, 32'hFFFF, 32'h0002, 1'b1, 1'b0);
        run_op(1, 32'h1000, 32'h1000, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        logic bz, vl;
        logic [63:0] y;
        int nv;
        run_op(0, 32'hFF, 32'h06, 1'b0, 1'b0);
        drive(0, 32'h12, 32'h34, 1'b0, 1'b1);
        tick();
        drive(0, 32'h12, 32'h34, 1'b0, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) last_y[i] = '0;
        sample(0, bz, vl, y);
        n_vec++;
        if (bz !== 1'b0 || vl !== 1'b0 || y !== 64'd0) begin
            n_miss++;
            $display("FAIL abort: got busy=%b valid=%b y=%h expected 0/0/0", bz, vl, y);
        end
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sample(0, bz, vl, y);
            if (vl !== 1'b0 || bz !== 1'b0) nv++;
        end
        n_vec++;
        if (nv != 0) begin
            n_miss++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", nv);
        end
        run_op(0, 32'h03, 32'h05, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic bz, vl;
        logic [63:0] y;
        logic [63:0] ys [2];
        int nv, gap;
        ys[0] = '0; ys[1] = '0;
        nv = 0; gap = 0;
        drive(0, 32'h0F, 32'h11, 1'b0, 1'b1);
        tick();
        for (int t = 1; t <= 40; t++) begin
            if (nv == 0) drive(0, rnd(8), rnd(8), 1'($urandom & 1), 1'b1);
            tick();
            sample(0, bz, vl, y);
            if (vl === 1'b1) begin
                if (nv < 2) ys[nv] = y;
                nv++;
                if (nv == 1) drive(0, 32'h03, 32'h07, 1'b0, 1'b1);
                if (nv == 2) drive(0, 32'h03, 32'h07, 1'b0, 1'b0);
            end else if (nv == 1 && bz !== 1'b1) begin
                gap++;
            end
        end
        $display("b2b y0=%h y1=%h pulses=%0d gap=%0d", ys[0], ys[1], nv, gap);
        n_vec++;
        if (ys[0] !== 64'h00FF) begin
            n_miss++;
            $display("FAIL b2b_first: got %h expected 00ff", ys[0]);
        end
        n_vec++;
        if (ys[1] !== 64'h0015) begin
            n_miss++;
            $display("FAIL b2b_second: got %h expected 0015", ys[1]);
        end
        n_vec++;
        if (nv != 2) begin
            n_miss++;
            $display("FAIL b2b_pulses: got %0d expected 2", nv);
        end
        n_vec++;
        if (gap != 1) begin
            n_miss++;
            $display("FAIL b2b_gap: got %0d idle cycles expected 1", gap);
        end
        last_y[0] = 64'h0015;
    endtask

    task automatic test_random;
        for (int idx = 0; idx < 2; idx++) begin
            for (int i = 0; i < 1000; i++) begin
                run_op(idx, rnd(wid(idx)), rnd(wid(idx)), 1'(i % 2), 1'b1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 0, 0, 1'b0, 1'b0);
            last_y[i] = '0;
        end
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
